spart_tx: RTL and testbench

SPART_TX -- requirements
Module: spart_tx

---
 rtl/spart_tx_pkg.sv | 15 +
 rtl/spart_tx_fifo.sv | 68 ++++++
 rtl/spart_tx.sv | 127 ++++++++++++
 tb/tb_spart_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/spart_tx_pkg.sv
// Shared types and default constants for the spart_tx transmit path.
package spart_tx_pkg;

  localparam int unsigned DEFAULT_DEPTH        = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/spart_tx_fifo.sv
// Byte queue feeding the serializer. Pushes are dropped while full, even if a
// pop happens in the same cycle; pops are ignored while empty.
module spart_tx_fifo
  import spart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^AW.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spart_tx.sv
// Queued UART-style transmitter: 8N1 framing, LSB first, registered TxD.
module spart_tx
  import spart_tx_pkg::*;
#(
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   send,
  input  logic [7:0]             data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tx_busy,
  output logic                   TxD
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          baud_last;

  spart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (send),
    .pop_i   (fifo_pop),
    .wdata_i (data),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign tx_busy   = (state_q != ST_IDLE);
  assign TxD       = txd_q;

  // State, counters, shift register and line flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic; counters clear on every state transition.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (fifo_pop) begin
          state_d = ST_START;
          shift_d = fifo_rdata;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          state_d = ST_IDLE;
          baud_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level decoded from the next state so TxD comes straight off a flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_IDLE:  txd_d = 1'b1;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx with DEPTH=4, CLKS_PER_BIT=4.
module tb_spart_tx;

  logic       clk;
  logic       rst_n;
  logic       send;
  logic [7:0] data;
  logic       full;
  logic [2:0] count;
  logic       tx_busy;
  logic       TxD;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  spart_tx #(
    .DEPTH        (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .send    (send),
    .data    (data),
    .full    (full),
    .count   (count),
    .tx_busy (tx_busy),
    .TxD     (TxD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check a 40-cycle frame from cycle index first_k (0 = first START cycle);
  // returns positioned in the IDLE cycle after STOP.
  task automatic check_frame(input logic [7:0] b, input int unsigned first_k);
    logic exp_bit;
    int   idx;
    for (int unsigned k = first_k; k < 40; k++) begin
      if (k < 4) exp_bit = 1'b0;
      else if (k >= 36) exp_bit = 1'b1;
      else begin
        idx     = int'(k / 4) - 1;
        exp_bit = b[idx];
      end
      check_eq("frame_txd", {31'd0, TxD}, {31'd0, exp_bit});
      check_eq("frame_busy", {31'd0, tx_busy}, 32'd1);
      step();
    end
  endtask

  task automatic check_idle_line(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check_eq("idle_txd", {31'd0, TxD}, 32'd1);
      check_eq("idle_busy", {31'd0, tx_busy}, 32'd0);
      check_eq("idle_count", {29'd0, count}, 32'd0);
      step();
    end
  endtask

  logic [7:0] bytes3 [4];
  logic [7:0] bytes4 [3];

  initial begin
    rst_n = 1'b0;
    send  = 1'b0;
    data  = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset then idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      check_eq("rst_txd", {31'd0, TxD}, 32'd1);
      check_eq("rst_full", {31'd0, full}, 32'd0);
      check_eq("rst_count", {29'd0, count}, 32'd0);
      check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
      step();
    end

    // Single byte A5 into an empty queue.
    send = 1'b1; data = 8'hA5;
    step();
    send = 1'b0;
    check_eq("a5_count_after_push", {29'd0, count}, 32'd1);
    check_eq("a5_txd_before_pop", {31'd0, TxD}, 32'd1);
    check_eq("a5_busy_before_pop", {31'd0, tx_busy}, 32'd0);
    step();
    check_eq("a5_count_after_pop", {29'd0, count}, 32'd0);
    check_frame(8'hA5, 0);
    check_idle_line(5);

    // Five back-to-back sends fill the queue, a sixth is dropped.
    send = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data = 8'(i);
      step();
    end
    check_eq("burst_full", {31'd0, full}, 32'd1);
    check_eq("burst_count", {29'd0, count}, 32'd4);
    data = 8'h06;
    step();
    send = 1'b0;
    check_eq("drop_full", {31'd0, full}, 32'd1);
    check_eq("drop_count", {29'd0, count}, 32'd4);
    check_frame(8'h01, 4);
    check_eq("gap1_count", {29'd0, count}, 32'd4);
    bytes3[0] = 8'h02; bytes3[1] = 8'h03; bytes3[2] = 8'h04; bytes3[3] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      check_eq("gap_txd", {31'd0, TxD}, 32'd1);
      check_eq("gap_busy", {31'd0, tx_busy}, 32'd0);
      step();
      check_frame(bytes3[i], 0);
    end
    check_idle_line(45);

    // Send while full in the IDLE pop cycle: pop wins, byte dropped.
    send = 1'b1;
    data = 8'h11; step();
    data = 8'h22; step();
    data = 8'h33; step();
    data = 8'h44; step();
    data = 8'h55; step();
    send = 1'b0;
    check_eq("fp_fill_count", {29'd0, count}, 32'd4);
    check_frame(8'h11, 3);
    check_eq("fp_idle_full", {31'd0, full}, 32'd1);
    check_eq("fp_idle_count", {29'd0, count}, 32'd4);
    check_eq("fp_idle_busy", {31'd0, tx_busy}, 32'd0);
    send = 1'b1; data = 8'h66;
    step();
    send = 1'b0;
    check_eq("fp_pop_count", {29'd0, count}, 32'd3);
    check_eq("fp_pop_full", {31'd0, full}, 32'd0);
    check_frame(8'h22, 0);
    bytes4[0] = 8'h33; bytes4[1] = 8'h44; bytes4[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check_eq("fp_gap_busy", {31'd0, tx_busy}, 32'd0);
      step();
      check_frame(bytes4[i], 0);
    end
    check_idle_line(45);

    // Reset mid-DATA of FF with two bytes queued.
    send = 1'b1;
    data = 8'hFF; step();
    data = 8'hAA; step();
    data = 8'hBB; step();
    send = 1'b0;
    repeat (11) step();
    check_eq("mid_busy", {31'd0, tx_busy}, 32'd1);
    check_eq("mid_count", {29'd0, count}, 32'd2);
    check_eq("mid_txd", {31'd0, TxD}, 32'd1);
    rst_n = 1'b0;
    step();
    check_eq("abort_txd", {31'd0, TxD}, 32'd1);
    check_eq("abort_count", {29'd0, count}, 32'd0);
    check_eq("abort_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("abort_full", {31'd0, full}, 32'd0);
    rst_n = 1'b1;
    check_idle_line(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
